// File: rtl/time_seg_pkg.sv
// Shared glyphs, BCD digit type and field limits for the time-of-day display counter.
package time_seg_pkg;

   typedef logic [3:0] bcd_t;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_P     = 7'b0011000;

   localparam logic [9:0] MS_MAX      = 10'd999;
   localparam logic [5:0] SEC_MAX     = 6'd59;
   localparam logic [5:0] MIN_MAX     = 6'd59;
   localparam logic [4:0] HOUR_MAX_12 = 5'd12;
   localparam logic [4:0] HOUR_MAX_24 = 5'd23;

   function automatic bcd_t inc_wrap(input bcd_t d, input bcd_t last);
      return (d == last) ? 4'd0 : d + 4'd1;
   endfunction

   function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
      return {4'(v / 6'd10), 4'(v % 6'd10)};
   endfunction

endpackage

// File: rtl/time_keeper_seg_seg7_enc.sv
// Combinational BCD to active-low seven-segment encoder with a blanking input.
module seg7_enc
   import time_seg_pkg::*;
(
   input  bcd_t       bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/time_keeper_seg.sv
// BCD time-of-day counter (12h AM/PM, or 24h when TIME_24H_EN is defined) with
// registered seven-segment outputs for the VGA clock renderer.
module time_keeper_seg
   import time_seg_pkg::*;
#(
   parameter int CLK_HZ = 100000000,
   parameter int MS_DIV = CLK_HZ / 1000
) (
   input  logic        CLK,
   input  logic        RST_BTN,
   input  logic        RUN,
   input  logic        SET_LD,
   input  logic [4:0]  SET_HOUR,
   input  logic [5:0]  SET_MIN,
   input  logic        SET_PM,
   output logic        SET_ERR,
   output logic        SEC_TICK,
   output logic [62:0] con,
   output logic [6:0]  AP
);

   localparam int              PS_W    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(MS_DIV - 1);

`ifdef TIME_24H_EN
   localparam bcd_t        HR_T_RST = 4'd0;
   localparam bcd_t        HR_U_RST = 4'd0;
   localparam logic [62:0] CON_RST  = {SEG_0, SEG_0, {7{SEG_0}}};
   localparam logic [6:0]  AP_RST   = SEG_BLANK;
`else
   localparam bcd_t        HR_T_RST = 4'd1;
   localparam bcd_t        HR_U_RST = 4'd2;
   localparam logic [62:0] CON_RST  = {SEG_1, SEG_2, {7{SEG_0}}};
   localparam logic [6:0]  AP_RST   = SEG_A;
`endif

   logic [PS_W-1:0] presc;
   bcd_t            hr_t, hr_u, mn_t, mn_u, sc_t, sc_u, ms_h, ms_t, ms_u;
   bcd_t            hr_t_nx, hr_u_nx;
   logic            pm, pm_nx;
   logic            ms_tick, load_ok;
   logic            c_ms_u, c_ms_t, c_ms, c_sc_u, c_sec, c_mn_u, c_min;
   logic [7:0]      ld_hr, ld_mn;
   logic            blank_a;
   logic [6:0]      ap_p0;
   logic [8:0][3:0] dig_p0;
   logic [8:0][6:0] seg_p0;

   assign ms_tick = RUN && (presc == PS_LAST);
   assign ld_hr   = bin_to_bcd({1'b0, SET_HOUR});
   assign ld_mn   = bin_to_bcd(SET_MIN);

`ifdef TIME_24H_EN
   assign load_ok = (SET_HOUR <= HOUR_MAX_24) && (SET_MIN <= MIN_MAX);
`else
   assign load_ok = (SET_HOUR != 5'd0) && (SET_HOUR <= HOUR_MAX_12) && (SET_MIN <= MIN_MAX);
`endif

   // Ripple carries: each one means every lower digit is about to wrap.
   assign c_ms_u = (ms_u == 4'd9);
   assign c_ms_t = c_ms_u && (ms_t == 4'd9);
   assign c_ms   = c_ms_t && (ms_h == 4'd9);
   assign c_sc_u = c_ms   && (sc_u == 4'd9);
   assign c_sec  = c_sc_u && (sc_t == 4'd5);
   assign c_mn_u = c_sec  && (mn_u == 4'd9);
   assign c_min  = c_mn_u && (mn_t == 4'd5);

   always_comb begin
      hr_t_nx = hr_t;
      hr_u_nx = hr_u;
      pm_nx   = pm;
`ifdef TIME_24H_EN
      if (hr_t == 4'd2 && hr_u == 4'd3) begin
         hr_t_nx = 4'd0;
         hr_u_nx = 4'd0;
      end else if (hr_u == 4'd9) begin
         hr_t_nx = hr_t + 4'd1;
         hr_u_nx = 4'd0;
      end else begin
         hr_u_nx = hr_u + 4'd1;
      end
`else
      // AM/PM flips entering 12, not when leaving it.
      if (hr_t == 4'd1 && hr_u == 4'd2) begin
         hr_t_nx = 4'd0;
         hr_u_nx = 4'd1;
      end else if (hr_t == 4'd1 && hr_u == 4'd1) begin
         hr_u_nx = 4'd2;
         pm_nx   = ~pm;
      end else if (hr_u == 4'd9) begin
         hr_t_nx = 4'd1;
         hr_u_nx = 4'd0;
      end else begin
         hr_u_nx = hr_u + 4'd1;
      end
`endif
   end

   always_ff @(posedge CLK or negedge RST_BTN) begin
      if (!RST_BTN) begin
         presc    <= '0;
         hr_t     <= HR_T_RST;
         hr_u     <= HR_U_RST;
         mn_t     <= '0;
         mn_u     <= '0;
         sc_t     <= '0;
         sc_u     <= '0;
         ms_h     <= '0;
         ms_t     <= '0;
         ms_u     <= '0;
         pm       <= 1'b0;
         SET_ERR  <= 1'b0;
         SEC_TICK <= 1'b0;
      end else begin
         SET_ERR  <= SET_LD && !load_ok;
         SEC_TICK <= ms_tick && !SET_LD && c_ms;
         if (SET_LD) begin
            if (load_ok) begin
               hr_t  <= ld_hr[7:4];
               hr_u  <= ld_hr[3:0];
               mn_t  <= ld_mn[7:4];
               mn_u  <= ld_mn[3:0];
               sc_t  <= '0;
               sc_u  <= '0;
               ms_h  <= '0;
               ms_t  <= '0;
               ms_u  <= '0;
               presc <= '0;
`ifdef TIME_24H_EN
               pm    <= 1'b0;
`else
               pm    <= SET_PM;
`endif
            end
         end else if (RUN) begin
            presc <= ms_tick ? '0 : presc + 1'b1;
            if (ms_tick) begin
               ms_u <= inc_wrap(ms_u, 4'd9);
               if (c_ms_u) ms_t <= inc_wrap(ms_t, 4'd9);
               if (c_ms_t) ms_h <= inc_wrap(ms_h, 4'd9);
               if (c_ms)   sc_u <= inc_wrap(sc_u, 4'd9);
               if (c_sc_u) sc_t <= inc_wrap(sc_t, 4'd5);
               if (c_sec)  mn_u <= inc_wrap(mn_u, 4'd9);
               if (c_mn_u) mn_t <= inc_wrap(mn_t, 4'd5);
               if (c_min) begin
                  hr_t <= hr_t_nx;
                  hr_u <= hr_u_nx;
                  pm   <= pm_nx;
               end
            end
         end
      end
   end

   // ---- stage p0: encode current state; stage p1: registered display bus
`ifdef TIME_24H_EN
   assign blank_a = 1'b0;
   assign ap_p0   = SEG_BLANK;
`else
   assign blank_a = (hr_t == 4'd0);
   assign ap_p0   = pm ? SEG_P : SEG_A;
`endif

   assign dig_p0 = {hr_t, hr_u, mn_t, mn_u, sc_t, sc_u, ms_h, ms_t, ms_u};

   for (genvar i = 0; i < 9; i++) begin : g_enc
      seg7_enc u_enc (
         .bcd   (dig_p0[i]),
         .blank ((i == 8) ? blank_a : 1'b0),
         .seg   (seg_p0[i])
      );
   end

   always_ff @(posedge CLK or negedge RST_BTN) begin
      if (!RST_BTN) begin
         con <= CON_RST;
         AP  <= AP_RST;
      end else begin
         con <= seg_p0;
         AP  <= ap_p0;
      end
   end

endmodule

// File: tb/tb_time_keeper_seg.sv
// Scoreboard bench for time_keeper_seg: a millisecond-of-day reference model feeds expected display words.
module tb_time_keeper_seg;

   logic        CLK      = 1'b0;
   logic        RST_BTN  = 1'b0;
   logic        RUN      = 1'b0;
   logic        SET_LD   = 1'b0;
   logic [4:0]  SET_HOUR = '0;
   logic [5:0]  SET_MIN  = '0;
   logic        SET_PM   = 1'b0;
   logic        SET_ERR;
   logic        SEC_TICK;
   logic [62:0] con;
   logic [6:0]  AP;

   time_keeper_seg #(.CLK_HZ(1000)) dut (
      .CLK      (CLK),
      .RST_BTN  (RST_BTN),
      .RUN      (RUN),
      .SET_LD   (SET_LD),
      .SET_HOUR (SET_HOUR),
      .SET_MIN  (SET_MIN),
      .SET_PM   (SET_PM),
      .SET_ERR  (SET_ERR),
      .SEC_TICK (SEC_TICK),
      .con      (con),
      .AP       (AP)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       tag;
      logic [62:0] con;
      logic [6:0]  ap;
   } exp_t;

   exp_t sb[$];
   int   n_checks  = 0;
   int   n_errs    = 0;
   int   sec_ticks = 0;
   int   t_ms      = 0;

   always @(posedge CLK) if (SEC_TICK === 1'b1) sec_ticks++;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [6:0] glyph(input int d);
      case (d)
         0:  return 7'b0000001;
         1:  return 7'b1001111;
         2:  return 7'b0010010;
         3:  return 7'b0000110;
         4:  return 7'b1001100;
         5:  return 7'b0100100;
         6:  return 7'b0100000;
         7:  return 7'b0001111;
         8:  return 7'b0000000;
         9:  return 7'b0000100;
         11: return 7'b0001000;
         12: return 7'b0011000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [62:0] exp_con();
      int h24, hd, mi, s, ms;
      logic [6:0] ga;
      h24 = t_ms / 3600000;
      mi  = (t_ms / 60000) % 60;
      s   = (t_ms / 1000) % 60;
      ms  = t_ms % 1000;
`ifdef TIME_24H_EN
      hd = h24;
      ga = glyph(hd / 10);
`else
      hd = (h24 % 12 == 0) ? 12 : h24 % 12;
      ga = (hd >= 10) ? glyph(1) : glyph(10);
`endif
      return {ga, glyph(hd % 10), glyph(mi / 10), glyph(mi % 10), glyph(s / 10), glyph(s % 10),
              glyph(ms / 100), glyph((ms / 10) % 10), glyph(ms % 10)};
   endfunction

   function automatic logic [6:0] exp_ap();
`ifdef TIME_24H_EN
      return 7'b1111111;
`else
      return (t_ms >= 12 * 3600000) ? glyph(12) : glyph(11);
`endif
   endfunction

   function automatic void model_load(input int h, input int m, input bit pm);
`ifdef TIME_24H_EN
      t_ms = (h * 60 + m) * 60000;
`else
      t_ms = (((h % 12) + (pm ? 12 : 0)) * 60 + m) * 60000;
`endif
   endfunction

   function automatic void push_exp(input string tag);
      sb.push_back('{tag, exp_con(), exp_ap()});
   endfunction

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 64'(sb.size()), 64'd1);
      end else begin
         e = sb.pop_front();
         check({e.tag, ".con"}, 64'(con), 64'(e.con));
         check({e.tag, ".ap"}, 64'(AP), 64'(e.ap));
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic do_load(input int h, input int m, input bit pm, input string tag);
      model_load(h, m, pm);
      push_exp(tag);
      SET_HOUR = 5'(h);
      SET_MIN  = 6'(m);
      SET_PM   = pm;
      SET_LD   = 1'b1;
      RUN      = 1'b1;
      tick(1);
      SET_LD = 1'b0;
      RUN    = 1'b0;
      check({tag, ".err"}, 64'(SET_ERR), 64'd0);
      tick(1);
      pop_check();
   endtask

   task automatic bad_load(input int h, input int m, input string tag);
      push_exp(tag);
      SET_HOUR = 5'(h);
      SET_MIN  = 6'(m);
      SET_LD   = 1'b1;
      tick(1);
      SET_LD = 1'b0;
      check({tag, ".err_hi"}, 64'(SET_ERR), 64'd1);
      tick(1);
      check({tag, ".err_lo"}, 64'(SET_ERR), 64'd0);
      pop_check();
   endtask

   task automatic run_ms(input int n, input string tag);
      t_ms = (t_ms + n) % 86400000;
      push_exp(tag);
      RUN = 1'b1;
      tick(n);
      RUN = 1'b0;
      tick(1);
      pop_check();
   endtask

   initial begin
      #10000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int st;
      int bad_h[$];

      // held in reset, then released
      t_ms = 0;
      tick(2);
      push_exp("rst_hold");
      pop_check();
      RST_BTN = 1'b1;
      tick(1);
      push_exp("rst_rel");
      pop_check();
      check("rst.set_err", 64'(SET_ERR), 64'd0);
      check("rst.sec_tick", 64'(SEC_TICK), 64'd0);

      // 11:59 AM -> 12:00 PM with a pause halfway
      st = sec_ticks;
      do_load(11, 59, 1'b0, "ld_1159");
      run_ms(30000, "half_1159");
      push_exp("hold");
      tick(500);
      pop_check();
      run_ms(30000, "noon");
      check("sec_tick_count", 64'(sec_ticks - st), 64'd60);

      // 12:59 PM -> 01:00 PM
      do_load(12, 59, 1'b1, "ld_1259");
      run_ms(60000, "one_pm");

      // rejected loads leave the display alone
`ifdef TIME_24H_EN
      bad_h = '{24, 31};
`else
      bad_h = '{13, 0};
`endif
      foreach (bad_h[i]) bad_load(bad_h[i], 30, $sformatf("bad_hour_%0d", bad_h[i]));
      bad_load(5, 60, "bad_min_60");

      // asynchronous reset in the middle of a running count
      do_load(7, 33, 1'b1, "ld_0733");
      run_ms(345, "pre_rst");
      RUN = 1'b1;
      tick(3);
      #2;
      RST_BTN = 1'b0;
      t_ms = 0;
      push_exp("async_rst");
      #1;
      pop_check();
      check("async_rst.set_err", 64'(SET_ERR), 64'd0);
      check("async_rst.sec_tick", 64'(SEC_TICK), 64'd0);
      RUN = 1'b0;
      #1;
      RST_BTN = 1'b1;
      tick(2);
      push_exp("post_rst");
      pop_check();

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
